// File: rtl/traceback_mem_if.sv
// -----------------------------------------------------------------------------
// traceback_mem_if -- handshake bundle for the Viterbi traceback memory.
//
// Column input side (master -> slave):
//   dec[NS]          survivor decisions for one trellis column, bit s = state s
//   dec_valid        dec holds a valid column
//   dec_last         final column of the frame (qualifies dec_valid)
//   start_state[SW]  traceback start state, sampled with the final column
//   in_ready         (slave -> master) a column is accepted this cycle
// Decoded bit output side (slave -> master):
//   bit_out          decoded bit, oldest first
//   out_valid        bit_out is valid
//   out_last         final decoded bit of the frame (qualifies out_valid)
//   out_ready        (master -> slave) downstream accepts bit_out
//   frame_len[CW]    column count of the current/last frame
// -----------------------------------------------------------------------------
interface traceback_mem_if #(
   parameter int K     = 3,
   parameter int DEPTH = 8
);
   localparam int NS = 1 << (K - 1);
   localparam int SW = K - 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [NS-1:0] dec;
   logic          dec_valid;
   logic          dec_last;
   logic [SW-1:0] start_state;
   logic          in_ready;
   logic          bit_out;
   logic          out_valid;
   logic          out_last;
   logic          out_ready;
   logic [CW-1:0] frame_len;

   modport master (
      output dec, dec_valid, dec_last, start_state, out_ready,
      input  in_ready, bit_out, out_valid, out_last, frame_len
   );

   modport slave (
      input  dec, dec_valid, dec_last, start_state, out_ready,
      output in_ready, bit_out, out_valid, out_last, frame_len
   );
endinterface

// File: rtl/traceback_mem.sv
// -----------------------------------------------------------------------------
// traceback_mem -- frame-based Viterbi survivor memory with traceback.
//
// Collects up to DEPTH decision columns (FILL), walks them backwards from the
// latched start state one column per cycle (TRACE), then streams the decoded
// bits out oldest-first with a valid/ready handshake (OUT).
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset; discards any partial frame
//   bus   traceback_mem_if.slave (column input, bit output, frame_len)
// -----------------------------------------------------------------------------
module traceback_mem #(
   parameter int K     = 3,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   traceback_mem_if.slave  bus
);
   localparam int NS = 1 << (K - 1);
   localparam int SW = K - 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {FILL, TRACE, OUT} state_t;

   state_t        state_q,     state_d;
   logic [AW-1:0] wr_cnt_q,    wr_cnt_d;
   logic [AW-1:0] rd_cnt_q,    rd_cnt_d;
   logic [SW-1:0] cur_q,       cur_d;
   logic [CW-1:0] frame_len_q, frame_len_d;
   logic          in_ready_q,  in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q,  out_last_d;
   logic          bit_out_q,   bit_out_d;

   logic [NS-1:0]    dec_mem [DEPTH];
   logic [DEPTH-1:0] out_buf;
   logic             col_wr;
   logic             trace_wr;
   logic [AW-1:0]    rd_next;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      cur_d       = cur_q;
      frame_len_d = frame_len_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      bit_out_d   = bit_out_q;
      col_wr      = 1'b0;
      trace_wr    = 1'b0;
      rd_next     = rd_cnt_q + AW'(1);

      unique case (state_q)
         FILL: begin
            if (bus.dec_valid && in_ready_q) begin
               col_wr      = 1'b1;
               frame_len_d = CW'(wr_cnt_q) + CW'(1);
               if (bus.dec_last || wr_cnt_q == AW'(DEPTH - 1)) begin
                  // wr_cnt stays on the final column: it becomes the
                  // traceback column pointer and counts down from here.
                  cur_d      = bus.start_state;
                  in_ready_d = 1'b0;
                  state_d    = TRACE;
               end else begin
                  wr_cnt_d = wr_cnt_q + AW'(1);
               end
            end
         end

         TRACE: begin
            trace_wr = 1'b1;
            cur_d    = {cur_q[SW-2:0], dec_mem[wr_cnt_q][cur_q]};
            if (wr_cnt_q == '0) begin
               // Column 0's bit is being written this cycle, so present it
               // directly instead of reading the buffer back.
               state_d     = OUT;
               rd_cnt_d    = '0;
               out_valid_d = 1'b1;
               bit_out_d   = cur_q[SW-1];
               out_last_d  = (frame_len_q == CW'(1));
            end else begin
               wr_cnt_d = wr_cnt_q - AW'(1);
            end
         end

         OUT: begin
            if (out_valid_q && bus.out_ready) begin
               if (out_last_q) begin
                  state_d     = FILL;
                  wr_cnt_d    = '0;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  bit_out_d   = 1'b0;
               end else begin
                  rd_cnt_d   = rd_next;
                  bit_out_d  = out_buf[rd_next];
                  out_last_d = (CW'(rd_next) == frame_len_q - CW'(1));
               end
            end
         end

         default: state_d = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         cur_q       <= '0;
         frame_len_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         bit_out_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         cur_q       <= cur_d;
         frame_len_q <= frame_len_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         bit_out_q   <= bit_out_d;
      end
   end

   // NOTE: the storage arrays carry no reset; every entry is written before
   // it is read within a frame, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (col_wr)   dec_mem[wr_cnt_q] <= bus.dec;
      if (trace_wr) out_buf[wr_cnt_q] <= cur_q[SW-1];
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.bit_out   = bit_out_q;
   assign bus.frame_len = frame_len_q;
endmodule
